// File: rtl/inv_arbiter.sv
// Round-robin arbiter/sequencer sharing one Ed448 field inversion unit among NUM_REQ requesters.
// Optional INV_ARB_ZERO_BYPASS_EN: zero operands are answered directly (resp_data=0, zero_err pulse).
module inv_arbiter #(
   parameter int NUM_REQ    = 3,
   parameter int DATA_WIDTH = 448
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_REQ-1:0]            resp_valid,
   output logic [DATA_WIDTH-1:0]         resp_data,
   output logic                          busy,
   output logic                          inv_start,
   output logic [DATA_WIDTH-1:0]         inv_a,
   input  logic                          inv_done,
   input  logic [DATA_WIDTH-1:0]         inv_result
`ifdef INV_ARB_ZERO_BYPASS_EN
   ,
   output logic                          zero_err
`endif
);

   localparam int IDX_W = $clog2(NUM_REQ);

   typedef enum logic [2:0] {S_IDLE, S_START, S_ARM, S_WAIT, S_RESP} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [IDX_W-1:0]      r_rr_ptr;
   logic [IDX_W-1:0]      r_grant;
   logic [DATA_WIDTH-1:0] r_a;
   logic [DATA_WIDTH-1:0] r_resp_data;
   logic                  w_found;
   logic [IDX_W-1:0]      w_win;
   logic [DATA_WIDTH-1:0] w_operand;
   logic                  w_zero;

   // (base + k) mod NUM_REQ; both terms are below NUM_REQ so one subtraction suffices
   function automatic logic [IDX_W-1:0] f_idx(input logic [IDX_W-1:0] base, input int k);
      logic [IDX_W:0] s;
      s = {1'b0, base} + (IDX_W+1)'(k);
      if (s >= (IDX_W+1)'(NUM_REQ)) s = s - (IDX_W+1)'(NUM_REQ);
      return s[IDX_W-1:0];
   endfunction

   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!w_found && req_valid[f_idx(r_rr_ptr, k)]) begin
            w_found = 1'b1;
            w_win   = f_idx(r_rr_ptr, k);
         end
      end
   end

   assign w_operand = req_data[w_win*DATA_WIDTH +: DATA_WIDTH];

`ifdef INV_ARB_ZERO_BYPASS_EN
   logic r_zero;
   assign w_zero   = (w_operand == '0);
   assign zero_err = (r_state == S_RESP) && r_zero;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                             r_zero <= 1'b0;
      else if (r_state == S_IDLE && w_found) r_zero <= w_zero;
   end
`else
   assign w_zero = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // ARM exists only to skip a done level left high by the previous operation
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_found) w_state_nxt = w_zero ? S_RESP : S_START;
         S_START: w_state_nxt = S_ARM;
         S_ARM:   w_state_nxt = S_WAIT;
         S_WAIT:  if (inv_done) w_state_nxt = S_RESP;
         S_RESP:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready  = '0;
      resp_valid = '0;
      inv_start  = 1'b0;
      busy       = (r_state != S_IDLE);
      case (r_state)
         S_IDLE:  if (w_found) req_ready[w_win] = 1'b1;
         S_START: inv_start = 1'b1;
         S_RESP:  resp_valid[r_grant] = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rr_ptr    <= '0;
         r_grant     <= '0;
         r_a         <= '0;
         r_resp_data <= '0;
      end else begin
         if (r_state == S_IDLE && w_found) begin
            r_a     <= w_operand;
            r_grant <= w_win;
            if (w_zero) r_resp_data <= '0;
         end
         if (r_state == S_WAIT && inv_done) r_resp_data <= inv_result;
         if (r_state == S_RESP)             r_rr_ptr    <= f_idx(r_grant, 1);
      end
   end

   assign inv_a     = r_a;
   assign resp_data = r_resp_data;

endmodule
